cmd_issuer: RTL and testbench

Command issuer that generates the `{opcode, id}` command stream consumed by the nested-case command decoder. Upstream agents post abstract command requests; the block queues them, encodes each into an opcode/id pair, and issues it one or more times over a valid/ready handshake. Registered counters report issued and dropped commands for debug.

---
 rtl/cmd_issuer.sv | 192 +++++++++++++++++++
 tb/tb_cmd_issuer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_issuer
// Purpose  : Queues abstract command requests, encodes each into an
//            {opcode, id} pair and issues it (repeat + 1) times over a
//            valid/ready handshake toward the command decoder. Saturating
//            counters report issued beats and dropped reserved requests.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      request valid
//   in_ready      out  1      request accepted on in_valid & in_ready
//   in_kind       in   2      command kind (3 = reserved, dropped)
//   in_repeat     in   3      command issued in_repeat + 1 times
//   out_valid     out  1      command valid toward decoder
//   out_ready     in   1      decoder accepts on out_valid & out_ready
//   out_opcode    out  1      encoded opcode
//   out_id        out  1      encoded id
//   busy          out  1      FIFO non-empty or issue FSM active
//   issued_count  out  CNT_W  saturating count of accepted output beats
//   drop_count    out  CNT_W  saturating count of reserved-kind requests
// ============================================================================
module cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_repeat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_opcode,
  output logic             out_id,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [1:0]    KIND_RSVD  = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  // Each entry holds {kind, repeat}.
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [2:0]      remaining;

  logic            empty;
  logic            full;
  logic            accept;
  logic            push;
  logic            drop;
  logic            pop;
  logic            rem_dec;
  logic            beat;
  logic [1:0]      head_kind;
  logic [2:0]      head_rep;

  assign empty     = (level == '0);
  assign full      = (level == FULL_LEVEL);
  // No bypass: a full FIFO refuses even when a pop happens this cycle, which
  // also keeps out_ready off the in_ready path.
  assign in_ready  = !full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & (in_kind != KIND_RSVD);
  assign drop      = accept & (in_kind == KIND_RSVD);
  assign beat      = out_valid & out_ready;
  assign busy      = !empty | (state != IDLE);
  assign head_kind = mem[rd_ptr][4:3];
  assign head_rep  = mem[rd_ptr][2:0];

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    pop        = 1'b0;
    rem_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (remaining != 3'd0) begin
            rem_dec = 1'b1;
          end else if (!empty) begin
            // Back-to-back: load the next entry while the last beat retires.
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_kind, in_repeat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output command registers: loaded only at pop, so they stay frozen while
  // a beat is stalled by out_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_opcode <= 1'b0;
      out_id     <= 1'b0;
      remaining  <= 3'd0;
    end else if (pop) begin
      out_opcode <= (head_kind == 2'd2);
      out_id     <= (head_kind == 2'd1);
      remaining  <= head_rep;
    end else if (rem_dec) begin
      remaining  <= remaining - 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_count <= '0;
      drop_count   <= '0;
    end else begin
      if (beat && (issued_count != '1)) begin
        issued_count <= issued_count + 1'b1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_issuer
// Purpose  : Self-checking bench for cmd_issuer. A queue-based reference
//            model tracks pending requests and the command being issued;
//            every cycle the DUT outputs are compared against it. A second
//            instance with 2-bit counters checks saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_issuer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_kind;
  logic [2:0] in_repeat;
  logic       out_ready;

  logic       in_ready, out_valid, out_opcode, out_id, busy;
  logic [7:0] issued_count, drop_count;

  logic       s_in_ready, s_out_valid, s_out_opcode, s_out_id, s_busy;
  logic [1:0] s_issued_count, s_drop_count;

  always #5 clk = ~clk;

  cmd_issuer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_repeat(in_repeat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_id(out_id),
    .busy(busy), .issued_count(issued_count), .drop_count(drop_count)
  );

  cmd_issuer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_repeat(in_repeat),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_opcode(s_out_opcode), .out_id(s_out_id),
    .busy(s_busy), .issued_count(s_issued_count), .drop_count(s_drop_count)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int q_kind[$];
  int q_rep[$];
  bit m_loaded;     // a command is being offered on the output
  int m_left;       // beats still to deliver for that command
  bit m_op, m_id;   // last loaded encoding (held by the output registers)
  int m_issued, m_dropped;

  function automatic void model_reset();
    q_kind.delete();
    q_rep.delete();
    m_loaded  = 1'b0;
    m_left    = 0;
    m_op      = 1'b0;
    m_id      = 1'b0;
    m_issued  = 0;
    m_dropped = 0;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic void model_clock(input bit v, input int k, input int r, input bit rdy);
    bit accept;
    bit fire;
    bit have;
    int kk;
    accept = v && (q_kind.size() < DEPTH);
    fire   = m_loaded && rdy;
    have   = (q_kind.size() != 0);
    if (fire) m_issued++;
    if ((!m_loaded && have) || (fire && m_left == 1 && have)) begin
      kk       = q_kind.pop_front();
      m_left   = q_rep.pop_front() + 1;
      m_loaded = 1'b1;
      m_op     = (kk == 2);
      m_id     = (kk == 1);
    end else if (fire && m_left > 1) begin
      m_left--;
    end else if (fire) begin
      m_loaded = 1'b0;
    end
    if (accept) begin
      if (k == 3) m_dropped++;
      else begin
        q_kind.push_back(k);
        q_rep.push_back(r);
      end
    end
  endfunction

  task automatic compare_all();
    check("out_valid",  out_valid,  m_loaded);
    check("in_ready",   in_ready,   q_kind.size() < DEPTH);
    check("busy",       busy,       (q_kind.size() != 0) || m_loaded);
    check("out_opcode", out_opcode, m_op);
    check("out_id",     out_id,     m_id);
    check("issued_count", issued_count, sat(m_issued, 255));
    check("drop_count",   drop_count,   sat(m_dropped, 255));
    check("sat_out_valid",    s_out_valid,    m_loaded);
    check("sat_issued_count", s_issued_count, sat(m_issued, 3));
    check("sat_drop_count",   s_drop_count,   sat(m_dropped, 3));
  endtask

  // Drive one cycle (called just after a falling edge).
  task automatic step(input bit v, input int k, input int r, input bit rdy);
    in_valid  = v;
    in_kind   = k[1:0];
    in_repeat = r[2:0];
    out_ready = rdy;
    #1;
    compare_all();
    @(posedge clk);
    model_clock(v, k, r, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, rdy);
  endtask

  initial begin
    int bp[7];
    bp = '{1, 0, 0, 1, 1, 0, 1};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_kind   = 2'd0;
    in_repeat = 3'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: kind 1, repeat 0.
    step(1'b1, 1, 0, 1'b1);
    idle(4, 1'b1);
    check("single_issued", issued_count, 1);

    // Repeat with backpressure: kind 2, repeat 3.
    step(1'b1, 2, 3, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 0, 0, bp[i][0]);
    idle(4, 1'b1);
    check("repeat_issued", issued_count, 5);

    // FIFO full: five kind-0 pushes against a stalled output, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);  // refused: FIFO full
    idle(8, 1'b1);
    check("full_issued", issued_count, 10);

    // Reserved kinds around a legal one.
    step(1'b1, 3, 0, 1'b1);
    step(1'b1, 0, 0, 1'b1);
    step(1'b1, 3, 0, 1'b1);
    idle(4, 1'b1);
    check("rsvd_drop", drop_count, 2);
    check("rsvd_issued", issued_count, 11);

    // Long repeat; the 2-bit instance must hold at 3.
    step(1'b1, 0, 5, 1'b1);
    idle(8, 1'b1);

    // Randomized traffic with alternating stall-heavy phases.
    for (int i = 0; i < 1500; i++) begin
      bit v, rdy;
      v   = ($urandom % 4) != 0;
      rdy = ((i / 64) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      step(v, int'($urandom % 4), int'($urandom % 4), rdy);
    end

    // Asynchronous reset in the middle of a stalled SEND.
    step(1'b1, 2, 7, 1'b0);
    idle(3, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy",  busy, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_issued", issued_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1'b1);
    step(1'b1, 1, 1, 1'b1);
    idle(5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
